// File: rtl/control_sequencer.sv
// Microcoded control sequencer for an 8-bit SAP-style CPU.
// Steps T0..T4, combinational control word decode, halt latch.
module control_sequencer #(
    parameter bit EARLY_END = 1'b1
) (
    input  logic        clk,
    input  logic        clear,
    input  logic [3:0]  opcode,
    input  logic        carry_flag,
    input  logic        zero_flag,
    output logic [15:0] ctrl,
    output logic [2:0]  step,
    output logic        halted
);

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_STA = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [15:0] W_FETCH0 = 16'h4004;
    localparam logic [15:0] W_FETCH1 = 16'h1408;
    localparam logic [15:0] W_HLT    = 16'h8000;
    localparam logic [15:0] W_JUMP   = 16'h0802;

    logic [2:0]  last_step;
    logic [15:0] exec_word;

    always_comb begin
        last_step = T2;
        if (!EARLY_END) begin
            last_step = T4;
        end else begin
            case (opcode)
                OP_LDA, OP_STA: last_step = T3;
                OP_ADD, OP_SUB: last_step = T4;
                default:        last_step = T2;
            endcase
        end
    end

    // Execute-phase microcode; unlisted step/opcode pairs stay idle.
    always_comb begin
        exec_word = 16'h0000;
        case (step)
            T2: begin
                case (opcode)
                    OP_LDA, OP_ADD,
                    OP_SUB, OP_STA: exec_word = 16'h4800;
                    OP_LDI:         exec_word = 16'h0A00;
                    OP_JMP:         exec_word = W_JUMP;
                    OP_JC:          exec_word = carry_flag ? W_JUMP : 16'h0000;
                    OP_JZ:          exec_word = zero_flag ? W_JUMP : 16'h0000;
                    OP_OUT:         exec_word = 16'h0110;
                    OP_HLT:         exec_word = W_HLT;
                    default:        exec_word = 16'h0000;
                endcase
            end
            T3: begin
                case (opcode)
                    OP_LDA:         exec_word = 16'h1200;
                    OP_ADD, OP_SUB: exec_word = 16'h1020;
                    OP_STA:         exec_word = 16'h2100;
                    default:        exec_word = 16'h0000;
                endcase
            end
            T4: begin
                case (opcode)
                    OP_ADD:  exec_word = 16'h0281;
                    OP_SUB:  exec_word = 16'h02C1;
                    default: exec_word = 16'h0000;
                endcase
            end
            default: exec_word = 16'h0000;
        endcase
    end

    always_comb begin
        ctrl = 16'h0000;
        if (clear) begin
            ctrl = 16'h0000;
        end else if (halted) begin
            ctrl = W_HLT;
        end else begin
            case (step)
                T0:      ctrl = W_FETCH0;
                T1:      ctrl = W_FETCH1;
                default: ctrl = exec_word;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            step   <= T0;
            halted <= 1'b0;
        end else if (!halted) begin
            if (step == T2 && opcode == OP_HLT) begin
                halted <= 1'b1;
            end else if (step >= last_step) begin
                step <= T0;
            end else begin
                step <= step + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: one instance per EARLY_END
// setting, fed the same stimulus and checked against hand tables.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clear = 1'b1;
    logic [3:0]  opcode = 4'd0;
    logic        carry_flag = 1'b0;
    logic        zero_flag = 1'b0;
    logic [15:0] ctrl_e, ctrl_f;
    logic [2:0]  step_e, step_f;
    logic        halted_e, halted_f;

    int checks = 0;
    int errors = 0;

    localparam logic [15:0] BUS_MASK = 16'h1984;

    control_sequencer #(.EARLY_END(1'b1)) dut_e (
        .clk(clk), .clear(clear), .opcode(opcode),
        .carry_flag(carry_flag), .zero_flag(zero_flag),
        .ctrl(ctrl_e), .step(step_e), .halted(halted_e)
    );

    control_sequencer #(.EARLY_END(1'b0)) dut_f (
        .clk(clk), .clear(clear), .opcode(opcode),
        .carry_flag(carry_flag), .zero_flag(zero_flag),
        .ctrl(ctrl_f), .step(step_f), .halted(halted_f)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        opcode = 4'b1111;
        tick();
        tick();
        checks++;
        if (step_e !== 3'd0 || halted_e !== 1'b0 || ctrl_e !== 16'h0000) begin
            errors++;
            $display("FAIL reset_e: step=%0d halted=%b ctrl=%h, want 0 0 0000",
                     step_e, halted_e, ctrl_e);
        end
        checks++;
        if (step_f !== 3'd0 || halted_f !== 1'b0 || ctrl_f !== 16'h0000) begin
            errors++;
            $display("FAIL reset_f: step=%0d halted=%b ctrl=%h, want 0 0 0000",
                     step_f, halted_f, ctrl_f);
        end
        clear = 1'b0;
        #1;
        checks++;
        if (ctrl_e !== 16'h4004 || ctrl_f !== 16'h4004) begin
            errors++;
            $display("FAIL reset_release: ctrl=%h/%h, want 4004", ctrl_e, ctrl_f);
        end
    endtask

    task automatic test_instructions();
        logic [3:0]  ops [7] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hE};
        logic [15:0] c2  [7] = '{16'h4800, 16'h4800, 16'h4800, 16'h4800,
                                 16'h0A00, 16'h0802, 16'h0110};
        logic [15:0] c3  [7] = '{16'h1200, 16'h1020, 16'h1020, 16'h2100,
                                 16'h0000, 16'h0000, 16'h0000};
        logic [15:0] c4  [7] = '{16'h0000, 16'h0281, 16'h02C1, 16'h0000,
                                 16'h0000, 16'h0000, 16'h0000};
        int          lst [7] = '{3, 4, 4, 3, 2, 2, 2};
        logic [2:0]  xs_e, xs_f;
        logic [15:0] xc_e, xc_f, tw;
        for (int i = 0; i < 7; i++) begin
            opcode = ops[i];
            pulse_clear();
            for (int s = 0; s <= lst[i] + 1; s++) begin
                tw = (s == 2) ? c2[i] : (s == 3) ? c3[i] : c4[i];
                xs_e = (s <= lst[i]) ? 3'(s) : 3'd0;
                xc_e = (s == 0 || s > lst[i]) ? 16'h4004 :
                       (s == 1) ? 16'h1408 : tw;
                xs_f = (s <= 4) ? 3'(s) : 3'd0;
                xc_f = (s == 0 || s == 5) ? 16'h4004 :
                       (s == 1) ? 16'h1408 : tw;
                checks++;
                if (step_e !== xs_e || ctrl_e !== xc_e) begin
                    errors++;
                    $display("FAIL instr_e op=%h s=%0d: step=%0d ctrl=%h, want %0d %h",
                             ops[i], s, step_e, ctrl_e, xs_e, xc_e);
                end
                checks++;
                if (step_f !== xs_f || ctrl_f !== xc_f) begin
                    errors++;
                    $display("FAIL instr_f op=%h s=%0d: step=%0d ctrl=%h, want %0d %h",
                             ops[i], s, step_f, ctrl_f, xs_f, xc_f);
                end
                tick();
            end
        end
    endtask

    task automatic test_cond_jumps();
        logic [3:0]  ops [4] = '{4'h7, 4'h7, 4'h8, 4'h8};
        logic        cf  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic        zf  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [15:0] xc  [4] = '{16'h0802, 16'h0000, 16'h0802, 16'h0000};
        for (int i = 0; i < 4; i++) begin
            opcode = ops[i];
            carry_flag = cf[i];
            zero_flag = zf[i];
            pulse_clear();
            tick();
            tick();
            checks++;
            if (step_e !== 3'd2 || ctrl_e !== xc[i]) begin
                errors++;
                $display("FAIL jump_t2 case %0d: step=%0d ctrl=%h, want 2 %h",
                         i, step_e, ctrl_e, xc[i]);
            end
            tick();
            checks++;
            if (step_e !== 3'd0 || ctrl_e !== 16'h4004) begin
                errors++;
                $display("FAIL jump_wrap case %0d: step=%0d ctrl=%h, want 0 4004",
                         i, step_e, ctrl_e);
            end
        end
        carry_flag = 1'b0;
        zero_flag = 1'b0;
    endtask

    task automatic test_nop();
        logic [3:0] ops [6] = '{4'h0, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD};
        for (int i = 0; i < 6; i++) begin
            opcode = ops[i];
            carry_flag = 1'b1;
            zero_flag = 1'b1;
            pulse_clear();
            tick();
            tick();
            checks++;
            if (step_e !== 3'd2 || ctrl_e !== 16'h0000 || ctrl_f !== 16'h0000) begin
                errors++;
                $display("FAIL nop op=%h: step=%0d ctrl=%h/%h, want 2 0000",
                         ops[i], step_e, ctrl_e, ctrl_f);
            end
            tick();
            checks++;
            if (step_e !== 3'd0 || step_f !== 3'd3 || ctrl_f !== 16'h0000) begin
                errors++;
                $display("FAIL nop_next op=%h: step=%0d/%0d ctrl_f=%h, want 0/3 0000",
                         ops[i], step_e, step_f, ctrl_f);
            end
        end
        carry_flag = 1'b0;
        zero_flag = 1'b0;
    endtask

    task automatic test_halt();
        opcode = 4'hF;
        pulse_clear();
        tick();
        tick();
        checks++;
        if (step_e !== 3'd2 || halted_e !== 1'b0 || ctrl_e !== 16'h8000) begin
            errors++;
            $display("FAIL halt_t2: step=%0d halted=%b ctrl=%h, want 2 0 8000",
                     step_e, halted_e, ctrl_e);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            opcode = 4'(i);
            carry_flag = i[0];
            zero_flag = i[1];
            #1;
            checks++;
            if (step_e !== 3'd2 || halted_e !== 1'b1 || ctrl_e !== 16'h8000 ||
                step_f !== 3'd2 || halted_f !== 1'b1 || ctrl_f !== 16'h8000) begin
                errors++;
                $display("FAIL halted cyc %0d: e=%0d/%b/%h f=%0d/%b/%h, want 2/1/8000",
                         i, step_e, halted_e, ctrl_e, step_f, halted_f, ctrl_f);
            end
        end
        opcode = 4'hF;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #1;
        checks++;
        if (step_e !== 3'd0 || halted_e !== 1'b0 || ctrl_e !== 16'h4004 ||
            halted_f !== 1'b0) begin
            errors++;
            $display("FAIL halt_clear: step=%0d halted=%b/%b ctrl=%h, want 0 0 4004",
                     step_e, halted_e, halted_f, ctrl_e);
        end
        carry_flag = 1'b0;
        zero_flag = 1'b0;
    endtask

    task automatic test_clear_mid();
        for (int at = 0; at < 5; at++) begin
            opcode = 4'h2;
            pulse_clear();
            for (int s = 0; s < at; s++) tick();
            clear = 1'b1;
            #1;
            checks++;
            if (ctrl_e !== 16'h0000 || ctrl_f !== 16'h0000) begin
                errors++;
                $display("FAIL clear_force at T%0d: ctrl=%h/%h, want 0000",
                         at, ctrl_e, ctrl_f);
            end
            tick();
            clear = 1'b0;
            #1;
            checks++;
            if (step_e !== 3'd0 || step_f !== 3'd0 || ctrl_e !== 16'h4004) begin
                errors++;
                $display("FAIL clear_abort at T%0d: step=%0d/%0d ctrl=%h, want 0 4004",
                         at, step_e, step_f, ctrl_e);
            end
        end
    endtask

    task automatic test_bus_exclusive();
        logic [15:0] be, bf;
        for (int op = 0; op < 16; op++) begin
            for (int fl = 0; fl < 4; fl++) begin
                opcode = 4'(op);
                carry_flag = fl[0];
                zero_flag = fl[1];
                pulse_clear();
                for (int s = 0; s < 6; s++) begin
                    be = ctrl_e & BUS_MASK;
                    bf = ctrl_f & BUS_MASK;
                    checks++;
                    if (!$onehot0(be) || !$onehot0(bf)) begin
                        errors++;
                        $display("FAIL bus op=%h fl=%0d s=%0d: ctrl=%h/%h",
                                 op, fl, s, ctrl_e, ctrl_f);
                    end
                    tick();
                end
            end
        end
        carry_flag = 1'b0;
        zero_flag = 1'b0;
    endtask

    initial begin
        test_reset();
        test_instructions();
        test_cond_jumps();
        test_nop();
        test_halt();
        test_clear_mid();
        test_bus_exclusive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter EARLY_END, default 1: 1 = each instruction ends at its own last step; 0 = every instruction runs the fixed steps T0..T4.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 clear  input  1  reset; synchronous, active-high.
REQ-004 opcode  input  4  instruction-register upper nibble; valid from step T2 onward.
REQ-005 carry_flag  input  1  latched ALU carry flag.
REQ-006 zero_flag  input  1  latched ALU zero flag.
REQ-007 ctrl  output  16  control word; bits 15..0 = HLT MI RI RO IO II AI AO EO SU BI OI CE CO J FI.
REQ-008 step  output  3  current microstep, 0..4.
REQ-009 halted  output  1  high once HLT has executed, until clear.

Function
REQ-010 ctrl SHALL be combinational from step, opcode, carry_flag, zero_flag and halted; datapath loads occur on the rising edge that ends the step.
REQ-011 T0 ctrl = 0x4004 (CO MI) and T1 ctrl = 0x1408 (RO II CE) for every opcode.
REQ-012 T2..T4 ctrl per opcode (unlisted steps = 0x0000):
- LDA 0001: 0x4800, 0x1200
- ADD 0010: 0x4800, 0x1020, 0x0281
- SUB 0011: 0x4800, 0x1020, 0x02C1
- STA 0100: 0x4800, 0x2100
- LDI 0101: 0x0A00
- JMP 0110: 0x0802
- JC 0111: 0x0802 if carry_flag, else 0x0000
- JZ 1000: 0x0802 if zero_flag, else 0x0000
- OUT 1110: 0x0110
- HLT 1111: 0x8000
REQ-013 Opcodes 0000 and 1001..1101 SHALL decode as NOP: ctrl 0x0000 for T2..T4.
REQ-014 Last step with EARLY_END=1: LDA/STA 3; ADD/SUB 4; all others 2. With EARLY_END=0: 4 for all opcodes.
REQ-015 Not halted: step SHALL go to 0 on the edge after the last step, otherwise step+1; step never exceeds 4.
REQ-016 Jump decision SHALL use the flag values present during T2; a JC or JZ not taken still ends at T2.
REQ-017 Opcode is not latched; step 0..1 decode SHALL be independent of opcode.
REQ-018 On the edge ending HLT T2, halted SHALL set and step SHALL freeze at 2.
REQ-019 While halted, ctrl SHALL be 0x8000 and no other bit SHALL assert; clock edges SHALL not change state.
REQ-020 At most one bus driver (RO IO AO EO CO) SHALL be active in any ctrl word.

Reset
REQ-021 On a rising edge with clear=1: step=0, halted=0. clear overrides halt and step advance on the same edge.
REQ-022 While clear=1, ctrl SHALL be forced to 0x0000.
REQ-023 clear asserted mid-instruction (any step) SHALL abort it; the first cycle after release is T0 (ctrl=0x4004).

Verification
REQ-024 clear for 1 cycle, opcode=0001 -> steps 0,1,2,3,0; ctrl 0x4004, 0x1408, 0x4800, 0x1200, 0x4004.
REQ-025 opcode=0011 -> T4 ctrl=0x02C1, then step wraps to 0; with EARLY_END=0 and opcode=0101 -> T3, T4 = 0x0000, wrap after T4.
REQ-026 opcode=0111: carry_flag=1 -> T2 ctrl=0x0802; carry_flag=0 -> T2 ctrl=0x0000; both return to step 0 next.
REQ-027 opcode=1111 -> after T2, halted=1, step=2, ctrl=0x8000 for 10 cycles; then clear 1 cycle -> step=0, halted=0, ctrl=0x4004.
REQ-028 clear pulsed during ADD T3 -> that edge gives step=0; ctrl=0x0000 during clear, 0x4004 the next cycle.
REQ-029 Every step/opcode/flag combination -> ctrl has at most one of bits 12, 11, 8, 7, 2 set.
